// File: rtl/uart8_receiver_pkg.sv
// Shared UART receive definitions: frame width, bit-index width and FSM states.
package uart8_receiver_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_IDX_W     = 3;

  // 3-bit state encoding shared with the transmitter; codes 5..7 are unused.
  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START_BIT = 3'd2,
    ST_DATA_BITS = 3'd3,
    ST_STOP_BIT  = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart8_receiver_if.sv
// UART receiver bus: enable and serial line in, byte and status strobes out.
//   en_i   : receive enable (gates new frames only)
//   rx_i   : asynchronous serial line, idles high
//   data_o : last good byte
//   done_o : one-cycle good-byte strobe
//   busy_o : frame in progress
//   err_o  : one-cycle framing-error strobe
interface uart8_receiver_if;
  import uart8_receiver_pkg::*;

  logic                      en_i;
  logic                      rx_i;
  logic [UART_DATA_BITS-1:0] data_o;
  logic                      done_o;
  logic                      busy_o;
  logic                      err_o;

  modport master (output en_i, rx_i, input data_o, done_o, busy_o, err_o);
  modport slave  (input en_i, rx_i, output data_o, done_o, busy_o, err_o);
endinterface

// File: rtl/uart8_receiver_sync2.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 (idle line).
//   clk : destination clock
//   rst : synchronous active-high reset
//   d_i : asynchronous input
//   q_o : synchronized output
module uart8_receiver_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart8_receiver.sv
// 8N1 UART receiver: oversampled start/data/stop sampling, LSB-first shift,
// registered byte output with one-cycle done / framing-error strobes.
//   clk : oversampled baud clock (OVERSAMPLE x baud)
//   rst : synchronous active-high reset
//   bus : uart8_receiver_if slave (en_i, rx_i in; data_o, done_o, busy_o, err_o out)
module uart8_receiver
  import uart8_receiver_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart8_receiver_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [UART_IDX_W-1:0]     idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [UART_DATA_BITS-1:0] out_q, out_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;
  logic                      rxs;
  logic                      rxs_d_q;
  logic                      start_edge;
  logic                      mid_start;
  logic                      mid_bit;

  uart8_receiver_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx_i),
    .q_o (rxs)
  );

  assign start_edge = bus.en_i & rxs_d_q & ~rxs;
  assign mid_start  = (cnt_q == HALF_LAST);
  assign mid_bit    = (cnt_q == BIT_LAST);

  // State register plus all datapath/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rxs_d_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rxs_d_q <= rxs;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:     state_d = ST_IDLE;
      ST_IDLE:      if (start_edge) state_d = ST_START_BIT;
      // A high line at mid start bit is a glitch: abandon quietly.
      ST_START_BIT: if (mid_start) state_d = rxs ? ST_IDLE : ST_DATA_BITS;
      ST_DATA_BITS: if (mid_bit && (idx_q == IDX_LAST)) state_d = ST_STOP_BIT;
      ST_STOP_BIT:  if (mid_bit) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    out_d   = out_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = (state_d == ST_START_BIT) || (state_d == ST_DATA_BITS) ||
              (state_d == ST_STOP_BIT);
    case (state_q)
      ST_START_BIT: begin
        if (mid_start) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      ST_DATA_BITS: begin
        if (mid_bit) begin
          cnt_d   = '0;
          shreg_d = {rxs, shreg_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + UART_IDX_W'(1);
        end
      end
      ST_STOP_BIT: begin
        if (mid_bit) begin
          cnt_d = '0;
          if (rxs) begin
            out_d  = shreg_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign bus.data_o = out_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = busy_q;
  assign bus.err_o  = err_q;

endmodule

// File: tb/tb_uart8_receiver.sv
// Directed + random bench for uart8_receiver with an expected-result scoreboard.
module tb_uart8_receiver;

  localparam int unsigned OS  = 16;
  localparam int unsigned LAT = 155;  // pad edge drive -> done visible, incl. synchronizer

  typedef struct {
    logic [7:0] data;
    bit         is_err;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic [7:0] last_good = 8'h00;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart8_receiver_if rx_bus ();

  uart8_receiver #(.OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rx_bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial line model: start, 8 data bits LSB first, stop; 16 clk per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit expect_evt, input int drop_en_bit);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_bus.rx_i = bits[i];
      if (i == 0 && expect_evt) begin
        e.data   = stop_bit ? b : last_good;
        e.is_err = !stop_bit;
        e.cyc    = cyc;
        sb.push_back(e);
        if (stop_bit) last_good = b;
      end
      if (drop_en_bit >= 0 && i == drop_en_bit + 1) rx_bus.en_i = 1'b0;
      repeat (OS) @(negedge clk);
    end
  endtask

  // Result monitor: every done/err strobe must match the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && (rx_bus.done_o === 1'b1 || rx_bus.err_o === 1'b1)) begin
      check("done_err_exclusive", 32'(rx_bus.done_o & rx_bus.err_o), 32'd0);
      check("busy_in_result_cycle", 32'(rx_bus.busy_o), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_result", 32'({rx_bus.done_o, rx_bus.err_o}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result_kind_err", 32'(rx_bus.err_o), 32'(mon_e.is_err));
        check("result_data", 32'(rx_bus.data_o), 32'(mon_e.data));
        check("result_latency", 32'(cyc - mon_e.cyc), 32'(LAT));
      end
    end
  end

  initial begin
    int         busy_cnt;
    logic [7:0] rb;
    logic [7:0] part;

    rst          = 1'b1;
    rx_bus.rx_i  = 1'b1;
    rx_bus.en_i  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(rx_bus.data_o), 32'h00);
    check("reset_done", 32'(rx_bus.done_o), 32'd0);
    check("reset_busy", 32'(rx_bus.busy_o), 32'd0);
    check("reset_err",  32'(rx_bus.err_o),  32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single good frame
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    repeat (20) @(negedge clk);
    check("t1_data", 32'(rx_bus.data_o), 32'hA5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    repeat (20) @(negedge clk);
    check("t2_data", 32'(rx_bus.data_o), 32'hFF);

    // 4-clk low glitch on an idle line
    busy_cnt    = 0;
    rx_bus.rx_i = 1'b0;
    for (int i = 0; i < 44; i++) begin
      if (i == 4) rx_bus.rx_i = 1'b1;
      @(negedge clk);
      if (rx_bus.busy_o === 1'b1) busy_cnt++;
    end
    check("t3_busy_bounded", 32'(busy_cnt <= 9), 32'd1);
    check("t3_busy_seen", 32'(busy_cnt > 0), 32'd1);
    check("t3_data_held", 32'(rx_bus.data_o), 32'hFF);

    // Framing error, then line held low (break)
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    busy_cnt = 0;
    repeat (48) begin
      @(negedge clk);
      if (rx_bus.busy_o === 1'b1) busy_cnt++;
    end
    check("t4_break_no_busy", 32'(busy_cnt), 32'd0);
    check("t4_data_held", 32'(rx_bus.data_o), 32'hFF);
    rx_bus.rx_i = 1'b1;
    repeat (32) @(negedge clk);

    // Enable low for a whole frame, then dropped mid-frame
    rx_bus.en_i = 1'b0;
    send_frame(8'h12, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("t5_ignored_data", 32'(rx_bus.data_o), 32'hFF);
    rx_bus.en_i = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b1, 2);
    rx_bus.en_i = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_data", 32'(rx_bus.data_o), 32'h5A);

    // Reset in the middle of data bit 4 of 0x96
    part        = 8'h96;
    rx_bus.rx_i = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_bus.rx_i = part[i];
      repeat (OS) @(negedge clk);
    end
    rx_bus.rx_i = part[4];
    repeat (OS / 2) @(negedge clk);
    check("t6_busy_before_rst", 32'(rx_bus.busy_o), 32'd1);
    rst         = 1'b1;
    rx_bus.rx_i = 1'b1;
    @(negedge clk);
    check("t6_rst_data", 32'(rx_bus.data_o), 32'h00);
    check("t6_rst_done", 32'(rx_bus.done_o), 32'd0);
    check("t6_rst_busy", 32'(rx_bus.busy_o), 32'd0);
    check("t6_rst_err",  32'(rx_bus.err_o),  32'd0);
    rst       = 1'b0;
    last_good = 8'h00;
    repeat (40) @(negedge clk);
    send_frame(8'h69, 1'b1, 1'b1, -1);
    repeat (20) @(negedge clk);
    check("t6_data", 32'(rx_bus.data_o), 32'h69);

    // Loopback-style random stream, back-to-back
    for (int n = 0; n < 256; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, 1'b1, -1);
    end

    for (int w = 0; w < 400 && sb.size() != 0; w++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
